led_trail_driver: RTL and testbench

- Display-side consumer of the wrap-around position counter: takes the 8-bit LED position and drives a bank of NUM_LEDS outputs.
- The current position is lit at full brightness. Previously visited LEDs fade out over several PWM frames, leaving a comet trail.
- Sits between the position counter and the board LED pins, in the same clock domain.

---
 rtl/led_trail_driver.sv | 90 +++++++++
 tb/tb_led_trail_driver.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_trail_driver.sv
// rtl/led_trail_driver.sv - Position-to-LED driver with PWM comet trail.
// Macro LED_TRAIL_EN enables the fading trail; otherwise only the head LED is lit.
module led_trail_driver #(
  parameter int NUM_LEDS = 16,
  parameter int PWM_BITS = 4,
  parameter int DECAY    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                blank,
  input  logic [7:0]          pos,
  input  logic [7:0]          max,
  output logic [NUM_LEDS-1:0] led,
  output logic [7:0]          head,
  output logic                frame_tick,
  output logic                pos_err
);

  localparam logic [PWM_BITS-1:0] FULL = '1;

  if (NUM_LEDS < 2 || NUM_LEDS > 256 || PWM_BITS < 1 || DECAY < 0) begin : g_bad_param
    $error("led_trail_driver: illegal parameter value");
  end

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                head_valid;
  logic                pos_ok;

  // Nine-bit compare so NUM_LEDS = 256 accepts every 8-bit position.
  assign pos_ok = ({1'b0, pos} < 9'(NUM_LEDS)) && (pos <= max);

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      head_valid <= 1'b0;
      pos_err    <= 1'b0;
      pwm_cnt    <= '0;
      frame_tick <= 1'b0;
    end else begin
      if (pos_ok) begin
        head       <= pos;
        head_valid <= 1'b1;
        pos_err    <= 1'b0;
      end else begin
        pos_err    <= 1'b1;
      end
      if (enable) pwm_cnt <= pwm_cnt + 1'b1;
      frame_tick <= enable && (pwm_cnt == FULL);
    end
  end

`ifdef LED_TRAIL_EN
  logic [PWM_BITS-1:0] bright [NUM_LEDS];

  // The registered head is both refreshed and excluded from decay, so a
  // departing head keeps full brightness until the first tick after it leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LEDS; i++) bright[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (head_valid && head == 8'(i))
          bright[i] <= FULL;
        else if (frame_tick && enable)
          bright[i] <= (int'(bright[i]) > DECAY) ? bright[i] - PWM_BITS'(DECAY) : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++)
        led[i] <= ~blank & (bright[i] > pwm_cnt);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= '0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++)
        led[i] <= ~blank & head_valid & (head == 8'(i)) & (pwm_cnt != FULL);
    end
  end
`endif

endmodule

// File: tb/tb_led_trail_driver.sv
// tb/tb_led_trail_driver.sv - Directed bench for led_trail_driver.
module tb_led_trail_driver;

  logic        clk = 1'b0;
  logic        rst, enable, blank;
  logic [7:0]  pos, max;
  logic [15:0] led;
  logic [7:0]  head;
  logic        frame_tick, pos_err;

  int tests = 0;
  int fails = 0;
  int cnt [16];
  int ticks;

`ifdef LED_TRAIL_EN
  localparam bit TRAIL = 1'b1;
`else
  localparam bit TRAIL = 1'b0;
`endif

  led_trail_driver #(.NUM_LEDS(16), .PWM_BITS(4), .DECAY(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .blank(blank), .pos(pos), .max(max),
    .led(led), .head(head), .frame_tick(frame_tick), .pos_err(pos_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] pos;
    logic [7:0] max;
    logic [7:0] exp_head;
    logic       exp_err;
    logic       chk_led;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Waits for a frame_tick sample, then one more so the following 16 samples
  // all reflect brightness after that tick's decay.
  task automatic sync_frame();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!frame_tick && n < 40);
    check("sync_tick", int'(frame_tick), 1);
    tick();
  endtask

  task automatic count_frame();
    ticks = 0;
    for (int j = 0; j < 16; j++) cnt[j] = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      ticks += int'(frame_tick);
      for (int j = 0; j < 16; j++) cnt[j] += int'(led[j]);
    end
  endtask

  function automatic int others(input int a, input int b);
    int s = 0;
    for (int j = 0; j < 16; j++) if (j != a && j != b) s += cnt[j];
    return s;
  endfunction

  initial begin
    int lit;
    int changed;
    logic [15:0] ref_led;

    vecs[0]  = '{1'b1, 1'b1, 8'd20,  8'd15,  8'd0,  1'b0, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 8'd20,  8'd15,  8'd0,  1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 8'd20,  8'd15,  8'd0,  1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 8'd16,  8'd15,  8'd0,  1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 8'd15,  8'd15,  8'd15, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 8'd10,  8'd9,   8'd15, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'd9,   8'd9,   8'd9,  1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 8'd0,   8'd0,   8'd0,  1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'd255, 8'd255, 8'd0,  1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'd5,   8'd15,  8'd5,  1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'd16,  8'd255, 8'd5,  1'b1, 1'b0};

    rst = 1'b1; enable = 1'b1; blank = 1'b0; pos = 8'd20; max = 8'd15;

    // Reset, then an out-of-range position must never light anything.
    repeat (3) tick();
    check("rst_led", int'(led), 0);
    check("rst_head", int'(head), 0);
    check("rst_tick", int'(frame_tick), 0);
    check("rst_err", int'(pos_err), 0);
    rst = 1'b0;
    tick();
    check("oor_err", int'(pos_err), 1);
    check("oor_head", int'(head), 0);
    lit = 0;
    repeat (64) begin tick(); lit |= int'(led); end
    check("oor_dark", lit, 0);

    // Steady head at 5.
    pos = 8'd5;
    tick();
    check("head5", int'(head), 5);
    check("err5", int'(pos_err), 0);
    sync_frame();
    for (int f = 0; f < 2; f++) begin
      count_frame();
      check("duty5", cnt[5], 15);
      check("tick_per_frame", ticks, 1);
      check("others5", others(5, 5), 0);
    end

    // Move to 6: LED 5 fades one step per frame.
    pos = 8'd6;
    tick();
    check("head6", int'(head), 6);
    sync_frame();
    count_frame();
    check("trail5_f1", cnt[5], TRAIL ? 14 : 0);
    check("duty6_f1", cnt[6], 15);
    count_frame();
    check("trail5_f2", cnt[5], TRAIL ? 13 : 0);
    check("duty6_f2", cnt[6], 15);
    check("tick_f2", ticks, 1);

    // Wrap 15 -> 0.
    pos = 8'd15;
    repeat (3) tick();
    check("head15", int'(head), 15);
    pos = 8'd0;
    tick();
    check("head0", int'(head), 0);
`ifdef LED_TRAIL_EN
    sync_frame();
    for (int f = 0; f < 15; f++) begin
      count_frame();
      check("trail15", cnt[15], 14 - f);
    end
    count_frame();
    check("trail15_off", cnt[15], 0);
`else
    tick();
    lit = int'(led[15]);
    repeat (16) begin tick(); lit |= int'(led[15]); end
    check("notrail15_off", lit, 0);
`endif

    // Blank for more than a frame, then resume immediately.
    pos = 8'd3;
    blank = 1'b1;
    tick();
    check("head3", int'(head), 3);
    lit = 0;
    repeat (20) begin tick(); lit |= int'(led); end
    check("blank_dark", lit, 0);
    blank = 1'b0;
    count_frame();
    check("unblank_duty3", cnt[3], 15);

    // Freeze mid-frame.
    sync_frame();
    repeat (5) tick();
    enable = 1'b0;
    tick();
    ref_led = led;
    changed = 0;
    ticks = 0;
    repeat (40) begin
      tick();
      ticks += int'(frame_tick);
      if (led != ref_led) changed++;
    end
    check("frozen_ticks", ticks, 0);
    check("frozen_led", changed, 0);
    pos = 8'd9;
    tick();
    check("frozen_head9", int'(head), 9);
    enable = 1'b1;
    lit = 0;
    repeat (17) begin tick(); lit |= int'(frame_tick); end
    check("resume_tick", lit, 1);

    // Reset mid-frame.
    pos = 8'd200;
    repeat (5) tick();
    check("pre_rst_err", int'(pos_err), 1);
    rst = 1'b1;
    tick();
    check("mid_rst_led", int'(led), 0);
    check("mid_rst_head", int'(head), 0);
    check("mid_rst_tick", int'(frame_tick), 0);
    check("mid_rst_err", int'(pos_err), 0);

    // Position sampling table.
    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst; enable = vecs[i].en; pos = vecs[i].pos; max = vecs[i].max;
      tick();
      check($sformatf("vec%0d_head", i), int'(head), int'(vecs[i].exp_head));
      check($sformatf("vec%0d_err", i), int'(pos_err), int'(vecs[i].exp_err));
      if (vecs[i].chk_led) check($sformatf("vec%0d_led", i), int'(led), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
